// File: rtl/chu_led_pattern.sv
// chu_led_pattern: MMIO slot core driving a W-bit LED bank in static, blink or rotate-chase mode
module chu_led_pattern #(
    parameter int W     = 8,
    parameter int CNT_W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         cs,
    input  logic         read,
    input  logic         write,
    input  logic [4:0]   addr,
    input  logic [31:0]  wr_data,
    output logic [31:0]  rd_data,
    output logic [W-1:0] dout
);
    logic [2:0]       ctrl;
    logic [W-1:0]     pattern, shreg, seed, led;
    logic [CNT_W-1:0] prescale, cnt;
    logic [15:0]      steps;
    logic             phase, wr_en, cfg_wr, tick, en;
    logic [1:0]       mode, a;

    always_comb begin
        a       = addr[1:0];
        mode    = ctrl[1:0];
        en      = ctrl[2];
        wr_en   = cs && write;
        cfg_wr  = wr_en && (a != 2'd3);
        tick    = en && !cfg_wr && (cnt == prescale);
        seed    = (a == 2'd1) ? wr_data[W-1:0] : pattern;
        led     = !en ? '0 : (mode == 2'd0) ? pattern : (mode == 2'd1) ? (phase ? '0 : pattern) : shreg;
        rd_data = (a == 2'd0) ? {29'b0, ctrl} :
                  (a == 2'd1) ? 32'(pattern) :
                  (a == 2'd2) ? 32'(prescale) : {16'b0, steps};
    end

    // a config write restarts the sequence from the seed and drops any coincident tick
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl     <= '0;
            pattern  <= '0;
            prescale <= '0;
            cnt      <= '0;
            shreg    <= '0;
            phase    <= 1'b0;
            steps    <= '0;
            dout     <= '0;
        end else begin
            dout <= led;
            if (cfg_wr) begin
                if (a == 2'd0) ctrl <= wr_data[2:0];
                if (a == 2'd1) pattern <= wr_data[W-1:0];
                if (a == 2'd2) prescale <= wr_data[CNT_W-1:0];
                cnt   <= '0;
                steps <= '0;
                phase <= 1'b0;
                shreg <= seed;
            end else if (en) begin
                cnt <= tick ? '0 : cnt + 1'b1;
                if (tick) begin
                    steps <= steps + 16'd1;
                    if (mode == 2'd1) phase <= ~phase;
                    if (mode == 2'd2) shreg <= {shreg[W-2:0], shreg[W-1]};
                    if (mode == 2'd3) shreg <= {shreg[0], shreg[W-1:1]};
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

// File: doc/chu_led_pattern.md
Name: chu_led_pattern

Overview:
- Parametrised general-purpose output slot core that drives a W-bit LED bank in one of four modes: static, blink, rotate-left chase, rotate-right chase.
- Pattern and rate are programmed over the standard MMIO slot interface.
- Successor to the fixed-speed LED output core: runtime-programmable prescaler, pattern and mode, plus register read-back.
- Sits in an MMIO slot; dout connects to board LEDs.

Parameters:
- W, 8, width of the LED output port and pattern register (2..32).
- CNT_W, 32, width of the prescaler counter and PRESCALE register (1..32).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- cs  input  1  slot select.
- read  input  1  read strobe (no side effects).
- write  input  1  write strobe.
- addr  input  5  register address; only addr[1:0] decoded.
- wr_data  input  32  write data.
- rd_data  output  32  read data.
- dout  output  W  LED outputs.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low; asserting it clears every register immediately.
- Reset values: ctrl=0, pattern=0, prescale=0, cnt=0, shreg=0, phase=0, steps=0, dout=0, rd_data follows its decode (0 at ctrl address).
- Write enable: wr_en = cs && write.
- Register map (addr[1:0]):
  - 0 CTRL (rw): bits[1:0] mode (0 static, 1 blink, 2 rotate-left, 3 rotate-right); bit[2] en. Other bits write-ignored, read 0.
  - 1 PATTERN (rw): bits[W-1:0]. Upper bits read 0.
  - 2 PRESCALE (rw): bits[CNT_W-1:0].
  - 3 STEPS (ro): bits[15:0] = tick count since last config write. Writes ignored.
- Read path: rd_data is purely combinational from addr and register state; no read latency.
- Config write: any write to addr 0, 1 or 2. On that edge:
  - the addressed register updates;
  - cnt <= 0, steps <= 0, phase <= 0;
  - shreg <= new PATTERN value (either the value just written or the current one).
- Prescaler:
  - When en=1 and no config write this cycle: cnt increments each clk. When cnt==prescale, tick=1 for that cycle and cnt <= 0.
  - Tick period is prescale+1 cycles; prescale=0 gives a tick every cycle.
  - When en=0, cnt holds at 0 and no ticks occur.
- Tick actions (registered, apply on the edge where tick=1):
  - steps <= steps+1, wrapping at 16 bits;
  - blink mode: phase <= ~phase;
  - rotate-left mode: shreg <= {shreg[W-2:0], shreg[W-1]};
  - rotate-right mode: shreg <= {shreg[0], shreg[W-1:1]}.
- Output (dout registered, one cycle after the state it reflects):
  - en=0: dout=0.
  - static: dout=pattern. Updates the cycle after the PATTERN write.
  - blink: dout = phase ? 0 : pattern. Starts lit after a config write, toggles each tick.
  - rotate modes: dout=shreg.
- Simultaneous config write and tick: the write wins; the tick is dropped (no steps increment, no shift, no toggle).
- Mode change with en=1: restarts from the PATTERN seed and phase 0.
- PATTERN=0 in rotate modes: dout stays 0. All-ones pattern: dout unchanged by rotation.
- Reset mid-operation: asynchronous clear to reset values; after deassertion the core idles disabled until CTRL is written.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with random bus activity -> dout=0, rd_data=0 at addr 0/1/2/3; release reset_n, no writes -> dout stays 0 for 100 cycles.
- Static: write PATTERN=0xA5 then CTRL=0x4 -> dout=0xA5 one cycle after the CTRL write; read addr 1 -> 0x000000A5; read addr 0 -> 0x4.
- Blink: PATTERN=0xFF, PRESCALE=3, CTRL=0x5 -> dout alternates 0xFF/0x00 every 4 cycles; after 10 ticks read addr 3 -> 10.
- Rotate-left: PATTERN=0x01, PRESCALE=0, CTRL=0x6 -> dout sequence 0x01,0x02,0x04,…,0x80,0x01 on consecutive cycles (wrap checked). CTRL=0x7 -> sequence 0x01,0x80,0x40,….
- Collision: PRESCALE=4, rotate-left running; issue a PATTERN write exactly on the tick cycle -> no shift that cycle, shreg=new pattern, steps=0, next tick 5 cycles later.
- Disable and mid-op reset: en cleared while blinking -> dout=0 next cycle, steps frozen; assert reset_n mid-rotation -> dout=0 immediately (async); all registers read 0.
